dma_irq_sequencer: RTL and testbench

- Owns the CPU status bits dma_ack and halt.
- Decides at each instruction boundary whether the CPU continues, yields the bus to DMA, or enters the interrupt microsequence.
- Sits between the microcode sequencer and the external DMA and interrupt sources.
- Drives the stall line that freezes the microsequencer.

---
 rtl/dma_irq_sequencer_pkg.sv | 27 ++
 rtl/dma_irq_sequencer_irq_prio_enc.sv | 36 +++
 rtl/dma_irq_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dma_irq_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_irq_sequencer_pkg.sv
// Shared CPU definitions for the DMA/interrupt sequencer.
// Contents: sequencer state encoding and the CPU status-register bit
// positions that dma_ack, irq_en and halt occupy.
package dma_irq_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DMA      = 2'd1,
        HALT     = 2'd2,
        IRQ_WAIT = 2'd3
    } seq_state_t;

    localparam int unsigned STAT_W           = 8;
    localparam int unsigned STAT_DMA_ACK_BIT = 0;
    localparam int unsigned STAT_IRQ_EN_BIT  = 1;
    localparam int unsigned STAT_HALT_BIT    = 4;

    // Places the sequencer-owned flags at their status-register positions.
    function automatic logic [STAT_W-1:0] seq_status_bits(input logic dma_ack, input logic halt);
        logic [STAT_W-1:0] s;
        s                   = '0;
        s[STAT_DMA_ACK_BIT] = dma_ack;
        s[STAT_HALT_BIT]    = halt;
        return s;
    endfunction

endpackage

// File: rtl/dma_irq_sequencer_irq_prio_enc.sv
// Combinational priority encoder for pending interrupts: lowest index wins.
// Ports:
//   pending  - latched interrupt requests
//   mask     - 1 = line enabled
//   valid_c  - at least one enabled line is pending
//   index_c  - index of the lowest enabled pending line (0 when none)
module irq_prio_enc
    import dma_irq_sequencer_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]         pending,
    input  logic [NUM_IRQ-1:0]         mask,
    output logic                       valid_c,
    output logic [$clog2(NUM_IRQ)-1:0] index_c
);

    localparam int unsigned IDX_W = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] req;

    assign req = pending & mask;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid_c = 1'b0;
        index_c = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                index_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dma_irq_sequencer.sv
// Instruction-boundary arbiter between CPU, DMA master and interrupts.
// Owns the dma_ack and halt status bits and the microsequencer stall.
// Optional build macro: SOL1_DMA_TIMEOUT_EN bounds each DMA grant to
// DMA_TIMEOUT cycles and pulses dma_err when a grant is cut short.
// Ports:
//   clk, arst         - clock, asynchronous active-high reset
//   fetch_boundary    - microcode at an instruction fetch point
//   irq_en            - global interrupt enable status bit
//   halt_set          - HALT instruction executing (with fetch_boundary)
//   dma_req / dma_ack - DMA bus request (level) / grant
//   halt, cpu_stall   - CPU halted / freeze microsequencer
//   irq_req, irq_mask - interrupt lines (level, async) / per-line enable
//   irq_take          - one-cycle pulse: enter interrupt microsequence
//   irq_vector        - index of the interrupt being taken
//   irq_ack           - microcode fetched the vector
//   dma_err           - DMA timeout pulse (0 without the optional feature)
module dma_irq_sequencer
    import dma_irq_sequencer_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned DMA_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       fetch_boundary,
    input  logic                       irq_en,
    input  logic                       halt_set,
    input  logic                       dma_req,
    output logic                       dma_ack,
    output logic                       halt,
    output logic                       cpu_stall,
    input  logic [NUM_IRQ-1:0]         irq_req,
    input  logic [NUM_IRQ-1:0]         irq_mask,
    output logic                       irq_take,
    output logic [$clog2(NUM_IRQ)-1:0] irq_vector,
    input  logic                       irq_ack,
    output logic                       dma_err
);

    localparam int unsigned IDX_W = $clog2(NUM_IRQ);

    if (NUM_IRQ < 2 || NUM_IRQ > 16 || DMA_TIMEOUT < 2) begin : g_param_check
        $error("dma_irq_sequencer: NUM_IRQ must be 2..16 and DMA_TIMEOUT >= 2");
    end

    seq_state_t         state, state_n;
    logic               ret_halt, ret_halt_n;
    logic               dma_ack_n, halt_n, cpu_stall_n, irq_take_n, dma_err_n;
    logic [IDX_W-1:0]   irq_vector_n;
    logic [NUM_IRQ-1:0] irq_sync, irq_prev, irq_edge, pending, pending_n, ack_clr;
    logic               prio_valid, eligible;
    logic [IDX_W-1:0]   prio_idx;
    logic               dma_go, timeout;

    // Two-stage capture: first flop samples the async lines, second gives the edge reference.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            irq_sync <= '0;
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_sync <= irq_req;
            irq_prev <= irq_sync;
            pending  <= pending_n;
        end
    end

    assign irq_edge  = irq_sync & ~irq_prev;
    assign ack_clr   = (state == IRQ_WAIT && irq_ack) ? (NUM_IRQ'(1) << irq_vector) : '0;
    // Edge is OR-ed after the clear so a fresh request on the acked line survives.
    assign pending_n = (pending & ~ack_clr) | irq_edge;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .pending (pending),
        .mask    (irq_mask),
        .valid_c (prio_valid),
        .index_c (prio_idx)
    );

    assign eligible = irq_en & prio_valid;

`ifdef SOL1_DMA_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(DMA_TIMEOUT);

    logic [CNT_W-1:0] dma_cnt;
    logic             dma_block;

    // Counter idles at zero outside DMA; block holds off regrant until dma_req drops.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dma_cnt   <= '0;
            dma_block <= 1'b0;
        end else begin
            dma_cnt <= (state == DMA) ? dma_cnt + CNT_W'(1) : '0;
            if (timeout)
                dma_block <= 1'b1;
            else if (!dma_req)
                dma_block <= 1'b0;
        end
    end

    assign timeout = (state == DMA) && (dma_cnt == CNT_W'(DMA_TIMEOUT - 1));
    assign dma_go  = dma_req & ~dma_block;
`else
    assign timeout = 1'b0;
    assign dma_go  = dma_req;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= RUN;
            ret_halt   <= 1'b0;
            dma_ack    <= 1'b0;
            halt       <= 1'b0;
            cpu_stall  <= 1'b0;
            irq_take   <= 1'b0;
            irq_vector <= '0;
            dma_err    <= 1'b0;
        end else begin
            state      <= state_n;
            ret_halt   <= ret_halt_n;
            dma_ack    <= dma_ack_n;
            halt       <= halt_n;
            cpu_stall  <= cpu_stall_n;
            irq_take   <= irq_take_n;
            irq_vector <= irq_vector_n;
            dma_err    <= dma_err_n;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_n      = state;
        ret_halt_n   = ret_halt;
        dma_ack_n    = dma_ack;
        halt_n       = halt;
        cpu_stall_n  = cpu_stall;
        irq_take_n   = 1'b0;
        irq_vector_n = irq_vector;
        dma_err_n    = 1'b0;
        case (state)
            RUN: begin
                if (fetch_boundary) begin
                    if (dma_go) begin
                        state_n     = DMA;
                        ret_halt_n  = 1'b0;
                        dma_ack_n   = 1'b1;
                        cpu_stall_n = 1'b1;
                    end else if (eligible) begin
                        state_n      = IRQ_WAIT;
                        irq_take_n   = 1'b1;
                        irq_vector_n = prio_idx;
                    end else if (halt_set) begin
                        state_n     = HALT;
                        halt_n      = 1'b1;
                        cpu_stall_n = 1'b1;
                    end
                end
            end
            DMA: begin
                if (!dma_req || timeout) begin
                    dma_ack_n = 1'b0;
                    dma_err_n = timeout;
                    if (ret_halt) begin
                        state_n = HALT;
                    end else begin
                        state_n     = RUN;
                        cpu_stall_n = 1'b0;
                    end
                end
            end
            HALT: begin
                if (dma_go) begin
                    state_n    = DMA;
                    ret_halt_n = 1'b1;
                    dma_ack_n  = 1'b1;
                end else if (eligible) begin
                    state_n      = IRQ_WAIT;
                    halt_n       = 1'b0;
                    cpu_stall_n  = 1'b0;
                    irq_take_n   = 1'b1;
                    irq_vector_n = prio_idx;
                end
            end
            IRQ_WAIT: begin
                if (irq_ack)
                    state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

endmodule

// File: tb/tb_dma_irq_sequencer.sv
// Scoreboard bench for dma_irq_sequencer: stimulus pushes expected output
// events; a negedge monitor pops one whenever dma_ack/halt/cpu_stall change
// or irq_take/dma_err pulse.
module tb_dma_irq_sequencer;

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned IDX_W   = $clog2(NUM_IRQ);
`ifdef SOL1_DMA_TIMEOUT_EN
    localparam int unsigned DMA_TIMEOUT = 16;
`else
    localparam int unsigned DMA_TIMEOUT = 1024;
`endif

    typedef struct {
        logic             dma_ack;
        logic             halt;
        logic             cpu_stall;
        logic             irq_take;
        logic [IDX_W-1:0] vec;
        logic             dma_err;
        int               dur;   // cycles since previous event, 0 = not checked
        int               id;
    } ev_t;

    logic               clk = 1'b0;
    logic               arst;
    logic               fetch_boundary, irq_en, halt_set, dma_req, irq_ack;
    logic               dma_ack, halt, cpu_stall, irq_take, dma_err;
    logic [NUM_IRQ-1:0] irq_req, irq_mask;
    logic [IDX_W-1:0]   irq_vector;

    ev_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ev_id    = 0;
    logic mon_en   = 1'b0;

    always #5 clk = ~clk;

    dma_irq_sequencer #(.NUM_IRQ(NUM_IRQ), .DMA_TIMEOUT(DMA_TIMEOUT)) dut (
        .clk            (clk),
        .arst           (arst),
        .fetch_boundary (fetch_boundary),
        .irq_en         (irq_en),
        .halt_set       (halt_set),
        .dma_req        (dma_req),
        .dma_ack        (dma_ack),
        .halt           (halt),
        .cpu_stall      (cpu_stall),
        .irq_req        (irq_req),
        .irq_mask       (irq_mask),
        .irq_take       (irq_take),
        .irq_vector     (irq_vector),
        .irq_ack        (irq_ack),
        .dma_err        (dma_err)
    );

    // Monitor: compares every observed output event against the queue head.
    logic [2:0] prev_st = 3'b000;
    int         since   = 0;
    always @(negedge clk) begin : monitor
        ev_t x;
        if (mon_en) begin
            since++;
            if ({dma_ack, halt, cpu_stall} != prev_st || irq_take || dma_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event t=%0t actual ack=%0b halt=%0b stall=%0b take=%0b vec=%0d err=%0b required none",
                             $time, dma_ack, halt, cpu_stall, irq_take, irq_vector, dma_err);
                end else begin
                    x = exp_q.pop_front();
                    if (dma_ack !== x.dma_ack || halt !== x.halt || cpu_stall !== x.cpu_stall ||
                        irq_take !== x.irq_take || dma_err !== x.dma_err ||
                        (x.irq_take && irq_vector !== x.vec) || (x.dur != 0 && since != x.dur)) begin
                        failures++;
                        $display("FAIL event%0d t=%0t actual ack=%0b halt=%0b stall=%0b take=%0b vec=%0d err=%0b dur=%0d required ack=%0b halt=%0b stall=%0b take=%0b vec=%0d err=%0b dur=%0d",
                                 x.id, $time, dma_ack, halt, cpu_stall, irq_take, irq_vector, dma_err, since,
                                 x.dma_ack, x.halt, x.cpu_stall, x.irq_take, x.vec, x.dma_err, x.dur);
                    end
                end
                prev_st = {dma_ack, halt, cpu_stall};
                since   = 0;
            end
        end
    end

    task automatic push(input logic a, input logic h, input logic s, input logic t,
                        input int v, input logic e, input int d);
        ev_t x;
        x.dma_ack = a; x.halt = h; x.cpu_stall = s; x.irq_take = t;
        x.vec = IDX_W'(v); x.dma_err = e; x.dur = d; x.id = ev_id;
        ev_id++;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic boundary();
        fetch_boundary = 1'b1;
        step(1);
        fetch_boundary = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        arst = 1'b1; fetch_boundary = 1'b0; irq_en = 1'b0; halt_set = 1'b0;
        dma_req = 1'b1; irq_ack = 1'b0; irq_req = '0; irq_mask = '0;

        // Reset state, with dma_req already asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_irq_take", 32'(irq_take), 32'd0);
        chk("rst_irq_vector", 32'(irq_vector), 32'd0);
        chk("rst_dma_err", 32'(dma_err), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        mon_en = 1'b1;

        // DMA granted at a boundary, held 7 cycles.
        push(1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 7);
        step(2);
        boundary();
        step(6);
        dma_req = 1'b0;
        step(2);

        // dma_req drops in the grant cycle: exactly one DMA cycle.
        dma_req = 1'b1;
        push(1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 1);
        boundary();
        dma_req = 1'b0;
        step(2);

        // Two simultaneous edges: lowest index first.
        irq_en = 1'b1; irq_mask = 8'hFF;
        irq_req = 8'b0010_0100;
        step(4);
        push(0, 0, 0, 1, 2, 0, 0);
        boundary();
        step(2);
        ack();
        push(0, 0, 0, 1, 5, 0, 0);
        step(1);
        boundary();
        // New edge on line 5 coinciding with its ack keeps it pending.
        irq_req = 8'b0000_0100;
        step(3);
        irq_req = 8'b0010_0100;
        step(1);
        ack();
        push(0, 0, 0, 1, 5, 0, 0);
        step(1);
        boundary();
        step(2);
        ack();
        irq_req = '0;
        step(3);

        // HALT, DMA from HALT for 4 cycles returns to HALT, irq 0 wakes.
        push(0, 1, 1, 0, 0, 0, 0);
        halt_set = 1'b1;
        boundary();
        halt_set = 1'b0;
        push(1, 1, 1, 0, 0, 0, 0);
        push(0, 1, 1, 0, 0, 0, 4);
        dma_req = 1'b1;
        step(4);
        dma_req = 1'b0;
        step(2);
        push(0, 0, 0, 1, 0, 0, 0);
        irq_req = 8'b0000_0001;
        step(5);
        ack();
        irq_req = '0;
        step(3);

        // irq_en=0 keeps the CPU halted; enabling wakes with vector 3.
        irq_en = 1'b0;
        push(0, 1, 1, 0, 0, 0, 0);
        halt_set = 1'b1;
        boundary();
        halt_set = 1'b0;
        irq_req = 8'b0000_1000;
        step(6);
        @(negedge clk);
        chk("halt_irq_disabled", 32'(halt), 32'd1);
        step(1);
        push(0, 0, 0, 1, 3, 0, 0);
        irq_en = 1'b1;
        step(3);
        ack();
        irq_req = '0;
        step(3);

        // Masked line stays pending while halted; unmasking wakes with vector 6.
        irq_mask = 8'hBF;
        push(0, 1, 1, 0, 0, 0, 0);
        halt_set = 1'b1;
        boundary();
        halt_set = 1'b0;
        irq_req = 8'b0100_0000;
        step(6);
        @(negedge clk);
        chk("halt_irq_masked", 32'(halt), 32'd1);
        step(1);
        push(0, 0, 0, 1, 6, 0, 0);
        irq_mask = 8'hFF;
        step(3);
        ack();
        irq_req = '0;
        step(3);

        // DMA and eligible irq at one boundary: DMA first, irq at next boundary.
        irq_req = 8'b0000_0010;
        step(4);
        dma_req = 1'b1;
        push(1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 3);
        boundary();
        step(2);
        dma_req = 1'b0;
        step(2);
        push(0, 0, 0, 1, 1, 0, 0);
        boundary();
        // dma_req during IRQ_WAIT is ignored.
        dma_req = 1'b1;
        step(3);
        dma_req = 1'b0;
        ack();
        irq_req = '0;
        step(3);

`ifdef SOL1_DMA_TIMEOUT_EN
        // Held request is cut after 16 cycles and not regranted until it drops.
        push(1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 1, 16);
        dma_req = 1'b1;
        boundary();
        step(25);
        boundary();
        step(2);
        @(negedge clk);
        chk("timeout_no_regrant", 32'(dma_ack), 32'd0);
        step(1);
        dma_req = 1'b0;
        step(2);
        dma_req = 1'b1;
        push(1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 1);
        boundary();
        dma_req = 1'b0;
        step(3);
`endif

        // Reset in the middle of DMA drops dma_ack without waiting for a clock.
        dma_req = 1'b1;
        push(1, 0, 1, 0, 0, 0, 0);
        boundary();
        step(2);
        push(0, 0, 0, 0, 0, 0, 0);
        #2 arst = 1'b1;
        #1;
        chk("async_rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("async_rst_cpu_stall", 32'(cpu_stall), 32'd0);
        dma_req = 1'b0;
        step(2);
        arst = 1'b0;
        step(5);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL events_outstanding actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
